// File: rtl/fcvt_issue_sched.sv
// Round-robin issue scheduler sharing one pipelined int-to-float converter
// between two requesters, with a tag pipe and a credit-limited result FIFO.
module fcvt_issue_sched #(
   parameter int LAT        = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_W       = 5
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            req0_valid,
   input  logic [31:0]     req0_x,
   input  logic [RD_W-1:0] req0_rd,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [31:0]     req1_x,
   input  logic [RD_W-1:0] req1_rd,
   output logic            req1_ready,
   output logic            unit_stage1_valid,
   output logic [31:0]     unit_x,
   input  logic [31:0]     unit_y,
   input  logic            unit_valid,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_y,
   output logic            rsp_id,
   output logic [RD_W-1:0] rsp_rd,
   output logic            err_tag
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [LAT-1:0]   tag_v;
   logic [LAT-1:0]   tag_g;
   logic [LAT-1:0]   tag_id;
   logic [RD_W-1:0]  tag_rd [LAT];

   logic [31:0]      fifo_y  [FIFO_DEPTH];
   logic             fifo_id [FIFO_DEPTH];
   logic [RD_W-1:0]  fifo_rd [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic rr;
   logic grant0;
   logic grant1;
   logic any_grant;
   logic credit_ok;
   int   inflight;
   logic tail_v;
   logic tail_g;
   logic push;
   logic pop;
   logic full;
   logic overflow;
   logic do_push;
   logic err_set;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   // Credits count both in-flight ops and buffered results, so a push can never find the FIFO full.
   always_comb begin
      inflight  = $countones(tag_v);
      credit_ok = (inflight + int'(count)) < FIFO_DEPTH;
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (rstn && !flush && credit_ok) begin
         if (req0_valid && req1_valid) begin
            grant0 = !rr;
            grant1 = rr;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
      any_grant = grant0 | grant1;
   end

   assign req0_ready        = grant0;
   assign req1_ready        = grant1;
   assign unit_stage1_valid = any_grant;
   assign unit_x            = grant0 ? req0_x : (grant1 ? req1_x : 32'd0);

   // Ghost bits follow flushed ops down the pipe so their late unit_valid is not reported as an error.
   always_comb begin
      tail_v   = tag_v[LAT-1];
      tail_g   = tag_g[LAT-1];
      full     = (count == CNT_W'(FIFO_DEPTH));
      pop      = rsp_valid && rsp_ready;
      push     = !flush && tail_v;
      overflow = push && full && !pop;
      do_push  = push && !overflow;
      err_set  = !flush && ((tail_v && !unit_valid) ||
                            (!tail_v && !tail_g && unit_valid) ||
                            overflow);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tag_v  <= '0;
         tag_g  <= '0;
         tag_id <= '0;
         for (int k = 0; k < LAT; k++) tag_rd[k] <= '0;
      end else begin
         for (int k = LAT - 1; k > 0; k--) begin
            tag_v[k]  <= flush ? 1'b0 : tag_v[k-1];
            tag_g[k]  <= flush ? (tag_v[k-1] | tag_g[k-1]) : tag_g[k-1];
            tag_id[k] <= tag_id[k-1];
            tag_rd[k] <= tag_rd[k-1];
         end
         tag_v[0]  <= any_grant;
         tag_g[0]  <= 1'b0;
         tag_id[0] <= grant1;
         tag_rd[0] <= grant1 ? req1_rd : req0_rd;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         rr      <= 1'b0;
         err_tag <= 1'b0;
      end else begin
         if (err_set) err_tag <= 1'b1;
         if (any_grant && req0_valid && req1_valid) rr <= grant0;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_y[wr_ptr]  <= unit_y;
         fifo_id[wr_ptr] <= tag_id[LAT-1];
         fifo_rd[wr_ptr] <= tag_rd[LAT-1];
      end
   end

   assign rsp_valid = (count != '0);
   assign rsp_y     = rsp_valid ? fifo_y[rd_ptr]  : 32'd0;
   assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : 1'b0;
   assign rsp_rd    = rsp_valid ? fifo_rd[rd_ptr] : '0;

endmodule

// File: tb/tb_fcvt_issue_sched.sv
// Bench for fcvt_issue_sched: queue-based reference model, converter stand-in,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fcvt_issue_sched;

   localparam int LAT        = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int RD_W       = 5;

   logic            clk;
   logic            rstn;
   logic            flush;
   logic            req0_valid;
   logic [31:0]     req0_x;
   logic [RD_W-1:0] req0_rd;
   logic            req0_ready;
   logic            req1_valid;
   logic [31:0]     req1_x;
   logic [RD_W-1:0] req1_rd;
   logic            req1_ready;
   logic            unit_stage1_valid;
   logic [31:0]     unit_x;
   logic [31:0]     unit_y;
   logic            unit_valid;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [31:0]     rsp_y;
   logic            rsp_id;
   logic [RD_W-1:0] rsp_rd;
   logic            err_tag;

   fcvt_issue_sched #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .RD_W(RD_W)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_rd(req0_rd), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_rd(req1_rd), .req1_ready(req1_ready),
      .unit_stage1_valid(unit_stage1_valid), .unit_x(unit_x),
      .unit_y(unit_y), .unit_valid(unit_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
      .rsp_id(rsp_id), .rsp_rd(rsp_rd), .err_tag(err_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int              due;
      logic            id;
      logic [RD_W-1:0] rd;
      logic [31:0]     x;
      logic            ghost;
   } pend_t;

   typedef struct {
      logic [31:0]     y;
      logic            id;
      logic [RD_W-1:0] rd;
   } rsp_t;

   pend_t pend[$];
   rsp_t  fifo_m[$];
   logic  rr_m;
   logic  err_m;
   logic  m_g0;
   logic  m_g1;
   int    cyc;
   int    tests;
   int    fails;

   logic        conv_v [LAT];
   logic [31:0] conv_y [LAT];
   logic        iss_v;
   logic [31:0] iss_x;
   logic        force_uv;

   // Round-to-nearest-even signed int to IEEE single.
   function automatic logic [31:0] itof(input logic [31:0] x);
      logic        s;
      logic [63:0] a;
      logic [63:0] mant;
      logic [63:0] rem;
      logic [63:0] half;
      int          msb;
      int          e;
      int          sh;
      if (x == 32'd0) return 32'd0;
      s   = x[31];
      a   = s ? {32'd0, (~x + 32'd1)} : {32'd0, x};
      msb = 0;
      for (int i = 0; i < 32; i++) if (a[i]) msb = i;
      e = msb + 127;
      if (msb <= 23) begin
         mant = a << (23 - msb);
      end else begin
         sh   = msb - 23;
         mant = a >> sh;
         rem  = a & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
         if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
         end
      end
      return {s, e[7:0], mant[22:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int real_inflight();
      int n = 0;
      foreach (pend[i]) if (!pend[i].ghost) n++;
      return n;
   endfunction

   task automatic drive_unit();
      unit_valid = conv_v[LAT-1] | force_uv;
      unit_y     = conv_y[LAT-1];
   endtask

   // Settle after the input change, then compare every DUT output to the model.
   task automatic observe();
      logic credit;
      #1;
      credit = (real_inflight() + fifo_m.size()) < FIFO_DEPTH;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (credit && !flush) begin
         if (req0_valid && req1_valid) begin
            m_g0 = !rr_m;
            m_g1 = rr_m;
         end else begin
            m_g0 = req0_valid;
            m_g1 = req1_valid;
         end
      end
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, m_g0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, m_g1});
      chk("stage1_valid", {31'd0, unit_stage1_valid}, {31'd0, m_g0 | m_g1});
      chk("unit_x", unit_x, m_g0 ? req0_x : (m_g1 ? req1_x : 32'd0));
      if (fifo_m.size() > 0) begin
         chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("rsp_y", rsp_y, fifo_m[0].y);
         chk("rsp_id", {31'd0, rsp_id}, {31'd0, fifo_m[0].id});
         chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, fifo_m[0].rd});
      end else begin
         chk("rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rsp_y_idle", rsp_y, 32'd0);
      end
      chk("err_tag", {31'd0, err_tag}, {31'd0, err_m});
      iss_v = unit_stage1_valid;
      iss_x = unit_x;
   endtask

   task automatic model_update();
      int    idx;
      logic  found;
      logic  found_real;
      pend_t t;
      idx        = -1;
      found      = 1'b0;
      found_real = 1'b0;
      foreach (pend[i]) if (pend[i].due == cyc) idx = i;
      if (idx >= 0) begin
         t          = pend[idx];
         found      = 1'b1;
         found_real = !t.ghost;
         pend.delete(idx);
      end
      if (flush) begin
         fifo_m.delete();
         foreach (pend[i]) pend[i].ghost = 1'b1;
      end else begin
         if (found_real && !unit_valid) err_m = 1'b1;
         if (!found && unit_valid) err_m = 1'b1;
         if (fifo_m.size() > 0 && rsp_ready) void'(fifo_m.pop_front());
         if (found_real) begin
            if (fifo_m.size() >= FIFO_DEPTH) err_m = 1'b1;
            else fifo_m.push_back('{itof(t.x), t.id, t.rd});
         end
         if (m_g0 || m_g1) begin
            pend.push_back('{cyc + LAT, m_g1, m_g1 ? req1_rd : req0_rd,
                             m_g1 ? req1_x : req0_x, 1'b0});
            if (req0_valid && req1_valid) rr_m = m_g0;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
      for (int k = LAT - 1; k > 0; k--) begin
         conv_v[k] = conv_v[k-1];
         conv_y[k] = conv_y[k-1];
      end
      conv_v[0] = iss_v;
      conv_y[0] = itof(iss_x);
      drive_unit();
   endtask

   task automatic model_reset();
      pend.delete();
      fifo_m.delete();
      rr_m  = 1'b0;
      err_m = 1'b0;
      iss_v = 1'b0;
      iss_x = 32'd0;
      for (int k = 0; k < LAT; k++) begin
         conv_v[k] = 1'b0;
         conv_y[k] = 32'd0;
      end
      drive_unit();
   endtask

   task automatic applyStimulus(input logic v0, input logic [31:0] x0, input logic [RD_W-1:0] r0,
                                input logic v1, input logic [31:0] x1, input logic [RD_W-1:0] r1,
                                input logic fl, input logic rr_in);
      req0_valid = v0; req0_x = x0; req0_rd = r0;
      req1_valid = v1; req1_x = x1; req1_rd = r1;
      flush = fl; rsp_ready = rr_in;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk(name, act, exp);
   endtask

   initial begin
      int          n;
      int          pops;
      logic [31:0] got_y [8];
      logic        got_id [8];

      tests    = 0;
      fails    = 0;
      cyc      = 0;
      force_uv = 1'b0;
      rstn     = 1'b0;
      model_reset();
      applyStimulus(1'b1, 32'd5, 5'd1, 1'b1, 32'd6, 5'd2, 1'b0, 1'b1);

      checkOutput("itof_1000", itof(32'd1000), 32'h447A0000);
      checkOutput("itof_1", itof(32'd1), 32'h3F800000);
      checkOutput("itof_m1", itof(32'hFFFFFFFF), 32'hBF800000);
      checkOutput("itof_rne", itof(32'h01000003), 32'h4B800002);

      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("rst_stage1", {31'd0, unit_stage1_valid}, 32'd0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_err", {31'd0, err_tag}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);

      // Single issue and its LAT-cycle latency.
      applyStimulus(1'b1, 32'd1000, 5'd3, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      observe();
      checkOutput("single_ready", {31'd0, req0_ready}, 32'd1);
      advance();
      applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      for (int k = 0; k < LAT; k++) begin
         observe();
         checkOutput("single_early", {31'd0, rsp_valid}, 32'd0);
         advance();
      end
      observe();
      checkOutput("single_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("single_y", rsp_y, 32'h447A0000);
      checkOutput("single_id", {31'd0, rsp_id}, 32'd0);
      checkOutput("single_rd", {27'd0, rsp_rd}, 32'd3);
      advance();
      observe();
      checkOutput("single_empty", {31'd0, rsp_valid}, 32'd0);
      advance();

      // Both requesters contending: grants alternate starting with req0.
      n = 0;
      for (int k = 0; k < 16; k++) begin
         if (k < 4) applyStimulus(1'b1, 32'd1, 5'd4, 1'b1, 32'hFFFFFFFF, 5'd9, 1'b0, 1'b1);
         else       applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
         observe();
         if (k < 4) begin
            checkOutput("rr_req0_ready", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_req1_ready", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         end
         if (rsp_valid && n < 8) begin
            got_y[n]  = rsp_y;
            got_id[n] = rsp_id;
            n++;
         end
         advance();
      end
      checkOutput("rr_rsp_count", n, 32'd4);
      for (int k = 0; k < 4 && k < n; k++) begin
         checkOutput("rr_rsp_y", got_y[k], (k % 2 == 0) ? 32'h3F800000 : 32'hBF800000);
         checkOutput("rr_rsp_id", {31'd0, got_id[k]}, (k % 2 == 0) ? 32'd0 : 32'd1);
      end

      // Stalled consumer: credits cap outstanding work at FIFO_DEPTH.
      n = 0;
      applyStimulus(1'b1, 32'd0, 5'd1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         observe();
         if (req0_ready) n++;
         advance();
      end
      checkOutput("stall_grants", n, FIFO_DEPTH);
      applyStimulus(1'b1, 32'd0, 5'd1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      observe();
      checkOutput("stall_pop_cycle_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("stall_head_y", rsp_y, 32'd0);
      pops = rsp_valid ? 1 : 0;
      advance();
      observe();
      checkOutput("stall_resume_ready", {31'd0, req0_ready}, 32'd1);
      if (rsp_valid) pops++;
      advance();
      applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         observe();
         if (rsp_valid) pops++;
         advance();
      end
      checkOutput("stall_total_pops", pops, FIFO_DEPTH + 1);

      // Flush with ops in flight: nothing comes back and no error is raised.
      applyStimulus(1'b1, 32'd7, 5'd2, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      observe(); advance();
      observe(); advance();
      applyStimulus(1'b1, 32'd7, 5'd2, 1'b0, 32'd0, 5'd0, 1'b1, 1'b1);
      observe();
      checkOutput("flush_no_grant", {31'd0, req0_ready}, 32'd0);
      advance();
      applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         observe();
         checkOutput("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         advance();
      end
      checkOutput("flush_err", {31'd0, err_tag}, 32'd0);
      applyStimulus(1'b1, 32'd5, 5'd7, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      observe(); advance();
      applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         observe();
         if (rsp_valid) begin
            n++;
            checkOutput("post_flush_y", rsp_y, 32'h40A00000);
            checkOutput("post_flush_rd", {27'd0, rsp_rd}, 32'd7);
         end
         advance();
      end
      checkOutput("post_flush_count", n, 32'd1);

      // Spurious unit_valid with an empty tag pipe sets the sticky error.
      force_uv = 1'b1;
      drive_unit();
      observe(); advance();
      force_uv = 1'b0;
      drive_unit();
      for (int k = 0; k < 3; k++) begin
         observe();
         checkOutput("err_sticky", {31'd0, err_tag}, 32'd1);
         advance();
      end

      // Asynchronous reset mid-operation forces every output low at once.
      applyStimulus(1'b1, 32'd123, 5'd5, 1'b1, 32'd456, 5'd6, 1'b0, 1'b0);
      observe(); advance();
      observe(); advance();
      #3;
      rstn = 1'b0;
      #1;
      checkOutput("arst_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("arst_req1_ready", {31'd0, req1_ready}, 32'd0);
      checkOutput("arst_stage1", {31'd0, unit_stage1_valid}, 32'd0);
      checkOutput("arst_unit_x", unit_x, 32'd0);
      checkOutput("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("arst_rsp_y", rsp_y, 32'd0);
      checkOutput("arst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
      checkOutput("arst_err", {31'd0, err_tag}, 32'd0);
      model_reset();
      applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      rstn = 1'b1;

      // Randomized traffic with alternating stall-heavy and free-flowing phases.
      for (int k = 0; k < 3000; k++) begin
         logic        v0;
         logic        v1;
         logic [31:0] x0;
         logic [31:0] x1;
         logic        rdy;
         v0  = ($urandom_range(0, 9) < 6);
         v1  = ($urandom_range(0, 9) < 6);
         x0  = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 20)) - 32'd10) : $urandom();
         x1  = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 20)) - 32'd10) : $urandom();
         rdy = ((k / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
         applyStimulus(v0, x0, RD_W'($urandom()), v1, x1, RD_W'($urandom()),
                       ($urandom_range(0, 49) == 0), rdy);
         observe();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fcvt_issue_sched.md
Name: fcvt_issue_sched

Overview:
- Scheduler that shares one pipelined int-to-float converter (itof) between two requesters: the integer pipe (req0) and the FPU issue port (req1).
- Performs round-robin arbitration and drives the converter's stage1_valid/x inputs.
- Tracks each in-flight conversion with a tag pipe and buffers results in a small FIFO, so a stalled consumer never loses a result.
- Sits between the core issue logic and the itof unit inside the FPU.

Parameters:
- LAT, 2, converter latency in cycles: unit_valid/unit_y appear LAT cycles after the issue edge.
- FIFO_DEPTH, 4, result FIFO entries; also the credit limit on outstanding operations. Must be at least 1.
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all in-flight and buffered results.
- req0_valid  in  1  requester 0 has an operation.
- req0_x  in  32  requester 0 signed integer operand.
- req0_rd  in  RD_W  requester 0 destination tag.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_x, req1_rd, req1_ready  same as req0, for requester 1.
- unit_stage1_valid  out  1  drives converter stage1_valid.
- unit_x  out  32  drives converter x.
- unit_y  in  32  converter result.
- unit_valid  in  1  converter result valid.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts the head.
- rsp_y  out  32  result float.
- rsp_id  out  1  originating requester.
- rsp_rd  out  RD_W  destination tag.
- err_tag  out  1  sticky protocol-mismatch flag.

Behaviour:
- Reset (rstn low, asynchronous): tag pipe valids = 0, FIFO empty, rr pointer = 0 (req0 has priority next), err_tag = 0. All outputs 0 while in reset.
- credit_ok = (inflight + fifo_count < FIFO_DEPTH).
  - inflight = number of valid tag-pipe stages.
  - Both counts are registered values. A pop in the current cycle does not free a credit until the next cycle.
- Arbitration is combinational from registered state.
  - If credit_ok and flush = 0, grant goes to the requester whose valid is high.
  - If both are valid, grant goes to the requester indicated by the rr pointer.
  - reqN_ready = grant to N. At most one ready per cycle. Ready is never asserted when the corresponding valid is low.
- Issue: unit_stage1_valid = any grant. unit_x = the granted requester's x; otherwise unit_x = 0.
  - On a grant edge, {1, id, rd} enters tag-pipe stage 0.
  - rr pointer moves to the non-granted requester only when both were valid. Otherwise it is unchanged.
- Tag pipe: LAT-stage shift register, advancing every cycle. Stage LAT-1 aligns with unit_valid.
- Completion: when the tail stage is valid, push {unit_y, id, rd} into the FIFO.
  - If tail valid != unit_valid, set err_tag. It stays set until reset.
  - Push only on tail valid, even when unit_valid is high.
- FIFO: first-word fall-through. rsp_valid = !empty; rsp_* reflect the head.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop keeps the count unchanged and preserves order.
  - Overflow is impossible by credit. If a push while full ever occurs, drop the push and set err_tag.
- Flush (sync, highest priority):
  - Clears tag-pipe valids and the FIFO, and suppresses grants in that cycle.
  - Results arriving after a flush are discarded, since their tags are cleared; err_tag is not set for these.
  - err_tag and the rr pointer are not changed by flush.
- Ordering: responses are returned in issue order. Throughput is 1 op/cycle while rsp_ready = 1.
- Latency from grant edge to rsp_valid: LAT cycles.

Test Plan:
- req0 x = 1000, rd = 3, single issue, rsp_ready = 1 -> req0_ready = 1 for one cycle; LAT cycles later rsp_valid = 1, rsp_y = 0x447A0000, rsp_id = 0, rsp_rd = 3; FIFO then empty.
- req0 and req1 held valid for 4 cycles (x = 1 / x = 0xFFFFFFFF) -> grants alternate 0,1,0,1; responses alternate 0x3F800000 / 0xBF800000 in issue order.
- rsp_ready = 0 with req0 streaming x = 0 -> exactly FIFO_DEPTH (4) grants, then req0_ready stays 0. Raising rsp_ready drains rsp_y = 0x00000000 ×4, and issue resumes one cycle after the first pop.
- Full FIFO with simultaneous pop and tail push -> count is unchanged and no entry is lost or reordered.
- Issue 2 ops, assert flush 1 cycle later -> no responses appear, rsp_valid = 0, err_tag = 0; the next request completes normally.
- Force unit_valid = 1 with an empty tag pipe -> err_tag = 1 and stays set; assert rstn = 0 mid-operation -> all outputs 0 immediately.
